// File: rtl/cram_cond_seq.sv
// cram_cond_seq: consumes the CRAM condition capture stage. On start it waits for a
// captured condition, selects the true/false CRAM region, issues a sequential burst
// of requests there, then pulses clear back to the capture stage so it can re-arm.
// A wait timeout and an abort keep a lost condition token from hanging the CRAM.
module cram_cond_seq #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int TMO_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_Start,
  input  logic [ADDR_W-1:0] I_TAddr,
  input  logic [ADDR_W-1:0] I_FAddr,
  input  logic [LEN_W-1:0]  I_Len,
  input  logic [TMO_W-1:0]  I_Tmo,
  input  logic              I_Abort,
  input  logic              I_CondValid,
  input  logic              I_Cond,
  input  logic              I_Ack,
  output logic              O_Busy,
  output logic              O_Req,
  output logic [ADDR_W-1:0] O_Addr,
  output logic              O_Clr,
  output logic              O_Done,
  output logic              O_Taken,
  output logic              O_TimeOut
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // Sequence parameters captured with I_Start; inputs are free to change afterwards.
  typedef struct packed {
    logic [ADDR_W-1:0] taddr;
    logic [ADDR_W-1:0] faddr;
    logic [LEN_W-1:0]  len;
    logic [TMO_W-1:0]  tmo;
  } cfg_t;

  state_t            state_q,  state_d;
  cfg_t              cfg_q,    cfg_d;
  logic [TMO_W-1:0]  wcnt_q,   wcnt_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              taken_q,  taken_d;
  logic              tflag_q,  tflag_d;

  logic              tmo_hit;

  // Timeout only armed for a nonzero limit; the condition beats it in the same cycle.
  assign tmo_hit = (cfg_q.tmo != '0) && (wcnt_q == cfg_q.tmo);

  // State and datapath registers; reset clears everything so no request survives it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      wcnt_q   <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      taken_q  <= 1'b0;
      tflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      wcnt_q   <= wcnt_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      taken_q  <= taken_d;
      tflag_q  <= tflag_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    wcnt_d   = wcnt_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    taken_d  = taken_q;
    tflag_d  = tflag_q;
    case (state_q)
      S_IDLE: begin
        if (I_Start) begin
          cfg_d.taddr = I_TAddr;
          cfg_d.faddr = I_FAddr;
          cfg_d.len   = I_Len;
          cfg_d.tmo   = I_Tmo;
          wcnt_d      = '0;
          tflag_d     = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (I_Abort) begin
          state_d = S_CLEAR;
        end else if (I_CondValid) begin
          taken_d  = I_Cond;
          addr_d   = I_Cond ? cfg_q.taddr : cfg_q.faddr;
          remain_d = cfg_q.len;
          state_d  = (cfg_q.len != '0) ? S_ISSUE : S_CLEAR;
        end else if (tmo_hit) begin
          tflag_d = 1'b1;
          state_d = S_CLEAR;
        end else if (wcnt_q != cfg_q.tmo) begin
          // Saturates at the limit; with a zero limit it simply stays at zero.
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        // An ack is always counted, even when abort ends the burst in the same cycle.
        if (I_Ack) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_W'(1)) state_d = S_CLEAR;
        end
        if (I_Abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state; no input reaches an output directly.
  assign O_Busy    = (state_q != S_IDLE);
  assign O_Req     = (state_q == S_ISSUE);
  assign O_Addr    = addr_q;
  assign O_Clr     = (state_q == S_CLEAR);
  assign O_Done    = (state_q == S_CLEAR);
  assign O_Taken   = taken_q;
  assign O_TimeOut = (state_q == S_CLEAR) && tflag_q;

endmodule
